i2c_poll_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of the I2C master and drives its address, RW and write-data inputs. It polls a sensor on a fixed period. For each of NUM_REGS consecutive registers it writes a register pointer and then reads one data byte. Read results go into a small result bank with per-entry valid flags, which avionics logic downstream reads. NACK and timeout are counted, and failed register reads are retried.

---
 rtl/i2c_poll_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_poll_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer: periodic register poller sitting in front of an I2C master.
// Each sweep writes a register pointer and reads one byte for NUM_REGS consecutive
// registers, storing results in a small bank with per-entry valid flags. Failed
// attempts are counted and retried. Optional transaction watchdog: define
// I2C_SEQ_TIMEOUT_EN to enable it (default build has no watchdog).
module i2c_poll_sequencer #(
   parameter logic [6:0] SLAVE_ADDR  = 7'b0011011,
   parameter int         NUM_REGS    = 4,
   parameter int         POLL_DIV    = 500000,
   parameter int         MAX_RETRY   = 3,
   parameter int         TIMEOUT_CYC = 8192
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       poll_now,
   input  logic [7:0] reg_base,
   output logic       m_start,
   output logic [6:0] m_addr,
   output logic       m_rw,
   output logic [7:0] m_wdata,
   input  logic       m_busy,
   input  logic       m_done,
   input  logic       m_nack,
   input  logic [7:0] m_rdata,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       sweep_done,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [TW-1:0] TMR_LAST  = TW'(POLL_DIV - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(NUM_REGS - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, FAIL, NEXT
   } state_t;

   state_t          state, state_n;
   logic [2:0]      idx, idx_n;
   logic [RW-1:0]   retry, retry_n;
   logic [7:0]      err_n;
   logic            start_n, rw_n, sweep_n;
   logic [7:0]      wdata_n;
   logic            tick_clr, bank_we, valid_clr;

   logic [TW-1:0]   tmr;
   logic            tmr_wrap, tick_pend, tick_go;
   logic            enable_q, enable_fall, abort, abort_now;
   logic            timeout;

   logic [7:0]      bank [8];
   logic [7:0]      valid;

   // The slave address never changes; it is a constant drive to the master.
   assign m_addr = SLAVE_ADDR;
   assign busy   = (state != IDLE);

   // Poll timer wraps every POLL_DIV cycles while enabled and is held at 0 otherwise.
   assign tmr_wrap = enable && (tmr == TMR_LAST);
   // A pending tick only launches a sweep while periodic polling is enabled.
   assign tick_go  = tick_pend && enable;

   // Dropping enable during a sweep makes the sweep end after the transaction in
   // flight; the fall is honoured in the very cycle it happens as well as latched.
   assign enable_fall = enable_q && !enable;
   assign abort_now   = abort || enable_fall;

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYC - 1);
   logic [12:0] to_cnt;

   // Watchdog: restarts with each m_start, advances while waiting for m_done.
   always_ff @(posedge clk_50) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (m_start)
         to_cnt <= '0;
      else if (state == W_WAIT || state == R_WAIT)
         to_cnt <= to_cnt + 13'd1;
   end

   // The m_start cycle still holds the previous count, so it is excluded.
   assign timeout = (state == W_WAIT || state == R_WAIT) && !m_start && (to_cnt == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      retry_n   = retry;
      err_n     = err_count;
      start_n   = 1'b0;
      rw_n      = m_rw;
      wdata_n   = m_wdata;
      sweep_n   = 1'b0;
      tick_clr  = 1'b0;
      bank_we   = 1'b0;
      valid_clr = 1'b0;
      case (state)
         IDLE: begin
            // A tick and poll_now together still launch only one sweep.
            if ((tick_go || poll_now) && !m_busy) begin
               tick_clr = 1'b1;
               idx_n    = 3'd0;
               retry_n  = '0;
               state_n  = W_ISSUE;
            end
         end
         W_ISSUE: begin
            if (!m_busy) begin
               start_n = 1'b1;
               rw_n    = 1'b0;
               wdata_n = reg_base + {5'd0, idx};
               state_n = W_WAIT;
            end
         end
         W_WAIT: begin
            if (m_done && !m_nack)
               state_n = abort_now ? IDLE : R_ISSUE;
            else if (m_done || timeout)
               state_n = FAIL;
         end
         R_ISSUE: begin
            // m_wdata keeps the pointer from the write; only direction changes.
            if (!m_busy) begin
               start_n = 1'b1;
               rw_n    = 1'b1;
               state_n = R_WAIT;
            end
         end
         R_WAIT: begin
            if (m_done && !m_nack) begin
               bank_we = 1'b1;
               state_n = NEXT;
            end else if (m_done || timeout) begin
               state_n = FAIL;
            end
         end
         FAIL: begin
            if (err_count != 8'hFF)
               err_n = err_count + 8'd1;
            retry_n = retry + RW'(1);
            if (retry_n <= RETRY_MAX) begin
               // A retry always repeats the pointer write before the read.
               state_n = abort_now ? IDLE : W_ISSUE;
            end else begin
               valid_clr = 1'b1;
               state_n   = NEXT;
            end
         end
         NEXT: begin
            retry_n = '0;
            if (abort_now) begin
               state_n = IDLE;
            end else if (idx == IDX_LAST) begin
               sweep_n = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n   = idx + 3'd1;
               state_n = W_ISSUE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sequencer state and registered master-facing outputs.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 3'd0;
         retry      <= '0;
         err_count  <= 8'd0;
         m_start    <= 1'b0;
         m_rw       <= 1'b0;
         m_wdata    <= 8'd0;
         sweep_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         retry      <= retry_n;
         err_count  <= err_n;
         m_start    <= start_n;
         m_rw       <= rw_n;
         m_wdata    <= wdata_n;
         sweep_done <= sweep_n;
      end
   end

   // Poll timer, pending-tick flag and sweep-abort latch.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         tmr       <= '0;
         tick_pend <= 1'b0;
         enable_q  <= 1'b0;
         abort     <= 1'b0;
      end else begin
         enable_q <= enable;
         if (!enable || tmr == TMR_LAST)
            tmr <= '0;
         else
            tmr <= tmr + TW'(1);
         // A wrap in the same cycle the flag is consumed re-arms it, so no tick is lost.
         tick_pend <= tmr_wrap || (tick_pend && !tick_clr);
         if (state_n == IDLE)
            abort <= 1'b0;
         else if (enable_fall && state != IDLE)
            abort <= 1'b1;
      end
   end

   // Result bank: successful reads store data; exhausted retries drop the valid flag only.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++)
            bank[i] <= 8'h00;
         valid <= 8'h00;
      end else if (bank_we) begin
         bank[idx]  <= m_rdata;
         valid[idx] <= 1'b1;
      end else if (valid_clr) begin
         valid[idx] <= 1'b0;
      end
   end

   // Combinational bank read; indices beyond the polled range read as empty.
   always_comb begin
      rd_data  = 8'h00;
      rd_valid = 1'b0;
      if ({1'b0, rd_idx} < 4'(NUM_REGS)) begin
         rd_data  = bank[rd_idx];
         rd_valid = valid[rd_idx];
      end
   end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Directed bench for i2c_poll_sequencer: a table of sweep scenarios against a
// scripted I2C master/sensor model, plus hand-written timing and reset sequences.
module tb_i2c_poll_sequencer;

   logic       clk_50 = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       poll_now = 1'b0;
   logic [7:0] reg_base = 8'h20;
   logic       m_start;
   logic [6:0] m_addr;
   logic       m_rw;
   logic [7:0] m_wdata;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic       m_nack = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   logic [2:0] rd_idx = 3'd0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       sweep_done;
   logic [7:0] err_count;
   logic       busy;

   i2c_poll_sequencer #(.POLL_DIV(100)) dut (
      .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .poll_now(poll_now),
      .reg_base(reg_base), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
      .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
      .m_rdata(m_rdata), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
      .sweep_done(sweep_done), .err_count(err_count), .busy(busy)
   );

   always #5 clk_50 = ~clk_50;

   int cyc = 0;
   always @(posedge clk_50) cyc <= cyc + 1;

   // Master/sensor model controls (written by the stimulus process)
   int         lat = 3;
   logic       hang = 1'b0;
   logic       f_rw = 1'b1;
   logic [7:0] f_ptr = 8'h00;
   int         f_lim = 0;
   logic [8:0] st_ptr = 9'h1FF;

   // Model state and activity log (written by the model process only)
   int         mcnt = 0;
   logic       cap_rw = 1'b0;
   logic [7:0] cap_wd = 8'h00;
   logic [7:0] ptr = 8'h00;
   int         n_wr = 0, n_rd = 0, n_sweep = 0, n_st = 0, nacks_given = 0, perr = 0;
   int         wr_cnt [256];
   int         st_time [16];

   // Sensor memory is mem[a] = a ^ 8'h80; NACKs are injected on one (rw, pointer) pair.
   always @(negedge clk_50) begin
      m_done = 1'b0;
      m_nack = 1'b0;
      if (sweep_done) n_sweep++;
      if (!rst_n) begin
         m_busy = 1'b0;
         mcnt   = 0;
      end else if (m_start) begin
         if (m_busy || m_addr != 7'b0011011) begin
            perr++;
            $display("protocol: m_start with busy=%0b addr=%h", m_busy, m_addr);
         end
         cap_rw = m_rw;
         cap_wd = m_wdata;
         if (!m_rw) begin
            ptr = m_wdata;
            n_wr++;
            wr_cnt[m_wdata]++;
            if ({1'b0, m_wdata} == st_ptr && n_st < 16) begin
               st_time[n_st] = cyc;
               n_st++;
            end
         end else begin
            n_rd++;
         end
         if (!hang) m_busy = 1'b1;
         mcnt = lat;
      end else if (m_busy) begin
         if (m_rw !== cap_rw || m_wdata !== cap_wd) begin
            perr++;
            $display("protocol: rw/wdata changed mid-transaction");
         end
         if (mcnt == 0) begin
            m_busy  = 1'b0;
            m_done  = 1'b1;
            m_rdata = ptr ^ 8'h80;
            if (cap_rw == f_rw && ptr == f_ptr && nacks_given < f_lim) begin
               m_nack = 1'b1;
               nacks_given++;
            end
         end else begin
            mcnt--;
         end
      end
   end

   typedef struct {
      logic [7:0]      base;
      logic            f_rw;
      logic [2:0]      f_entry;
      int              f_n;
      int              exp_wr;
      int              exp_rd;
      int              exp_ptr;
      logic [7:0]      exp_err;
      logic [3:0]      exp_vld;
      logic [3:0][7:0] exp_bank;
   } vec_t;

   vec_t vt [5];
   int   nvec = 0, nmis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   task automatic pulse_poll();
      @(negedge clk_50);
      poll_now = 1'b1;
      @(negedge clk_50);
      poll_now = 1'b0;
   endtask

   initial begin
      int s_sw, s_wr, s_rd, s_ptr, s_st, e0, k;

      // base, f_rw, f_entry, f_n, wr, rd, ptr writes, err, valid, bank[3..0]
      vt[0] = '{8'h20, 1'b1, 3'd0, 0, 4, 4, 1, 8'd0, 4'b1111, 32'hA3A2A1A0};
      vt[1] = '{8'hDA, 1'b1, 3'd2, 2, 6, 6, 3, 8'd2, 4'b1111, 32'h5D5C5B5A};
      vt[2] = '{8'h30, 1'b1, 3'd1, 4, 7, 7, 4, 8'd6, 4'b1101, 32'hB3B25BB0};
      vt[3] = '{8'hFE, 1'b1, 3'd0, 0, 4, 4, 1, 8'd6, 4'b1111, 32'h81807F7E};
      vt[4] = '{8'h10, 1'b0, 3'd0, 1, 5, 4, 2, 8'd7, 4'b1111, 32'h93929190};

      // Reset state
      tick(3);
      #1;
      check("rst_m_start", m_start, 0);
      check("rst_m_addr", m_addr, 7'b0011011);
      check("rst_m_rw", m_rw, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_count, 0);
      check("rst_sweep_done", sweep_done, 0);
      check("rst_valid0", rd_valid, 0);
      @(negedge clk_50);
      rst_n = 1'b1;
      tick(2);

      // Table-driven sweeps triggered by poll_now
      for (int v = 0; v < 5; v++) begin
         reg_base = vt[v].base;
         f_rw     = vt[v].f_rw;
         f_ptr    = vt[v].base + {5'd0, vt[v].f_entry};
         f_lim    = nacks_given + vt[v].f_n;
         s_sw = n_sweep; s_wr = n_wr; s_rd = n_rd; s_ptr = wr_cnt[f_ptr];
         pulse_poll();
         k = 0;
         while (n_sweep == s_sw && k < 2000) begin @(negedge clk_50); k++; end
         tick(20);
         check($sformatf("v%0d_sweeps", v), n_sweep - s_sw, 1);
         check($sformatf("v%0d_busy", v), busy, 0);
         check($sformatf("v%0d_err", v), err_count, vt[v].exp_err);
         check($sformatf("v%0d_writes", v), n_wr - s_wr, vt[v].exp_wr);
         check($sformatf("v%0d_reads", v), n_rd - s_rd, vt[v].exp_rd);
         check($sformatf("v%0d_ptr_writes", v), wr_cnt[f_ptr] - s_ptr, vt[v].exp_ptr);
         for (int i = 0; i < 4; i++) begin
            rd_idx = 3'(i);
            #1;
            check($sformatf("v%0d_bank%0d", v, i), rd_data, vt[v].exp_bank[i]);
            check($sformatf("v%0d_valid%0d", v, i), rd_valid, vt[v].exp_vld[i]);
            @(negedge clk_50);
         end
      end

      // Out-of-range read index
      rd_idx = 3'd4;
      #1;
      check("oob4_data", rd_data, 0);
      check("oob4_valid", rd_valid, 0);
      @(negedge clk_50);
      rd_idx = 3'd7;
      #1;
      check("oob7_data", rd_data, 0);
      @(negedge clk_50);

      // poll_now during a sweep is ignored
      reg_base = 8'h20;
      f_lim = nacks_given;
      s_sw = n_sweep; s_wr = n_wr;
      pulse_poll();
      tick(10);
      pulse_poll();
      tick(150);
      check("poll_mid_sweeps", n_sweep - s_sw, 1);
      check("poll_mid_writes", n_wr - s_wr, 4);

      // Periodic ticks: first sweep slow (overlaps the next tick), then fast
      lat = 12;
      st_ptr = 9'h020;
      s_st = n_st; s_sw = n_sweep;
      @(negedge clk_50);
      enable = 1'b1;
      e0 = cyc + 1;
      k = 0;
      while (n_sweep == s_sw && k < 400) begin @(negedge clk_50); k++; end
      lat = 3;
      k = 0;
      while (n_st < s_st + 4 && k < 400) begin @(negedge clk_50); k++; end
      tick(70);
      enable = 1'b0;
      check("tick_start1", st_time[s_st]     - e0, 101);
      check("tick_start2", st_time[s_st + 1] - e0, 226);
      check("tick_start3", st_time[s_st + 2] - e0, 301);
      check("tick_start4", st_time[s_st + 3] - e0, 401);
      tick(300);
      check("tick_stop_starts", n_st - s_st, 4);
      check("tick_stop_busy", busy, 0);
      st_ptr = 9'h1FF;

      // enable falling mid-transaction: finish it, go idle, no sweep_done
      s_sw = n_sweep; s_wr = n_wr; s_rd = n_rd;
      @(negedge clk_50);
      enable = 1'b1;
      k = 0;
      while (n_wr == s_wr && k < 200) begin @(negedge clk_50); k++; end
      tick(2);
      enable = 1'b0;
      tick(50);
      check("abort_busy", busy, 0);
      check("abort_sweeps", n_sweep - s_sw, 0);
      check("abort_writes", n_wr - s_wr, 1);
      check("abort_reads", n_rd - s_rd, 0);

      // Reset asserted while waiting on a read
      s_rd = n_rd;
      pulse_poll();
      k = 0;
      while (n_rd == s_rd && k < 200) begin @(negedge clk_50); k++; end
      check("rst_mid_reached_read", n_rd - s_rd, 1);
      rst_n = 1'b0;
      @(negedge clk_50);
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_err", err_count, 0);
      check("rst_mid_m_start", m_start, 0);
      for (int i = 0; i < 4; i++) begin
         rd_idx = 3'(i);
         #1;
         check($sformatf("rst_mid_valid%0d", i), rd_valid, 0);
         check($sformatf("rst_mid_data%0d", i), rd_data, 0);
         @(negedge clk_50);
      end
      rst_n = 1'b1;
      s_wr = n_wr; s_rd = n_rd;
      tick(200);
      check("rst_mid_no_start", (n_wr - s_wr) + (n_rd - s_rd), 0);

      // Master that never answers
      hang = 1'b1;
      st_ptr = 9'h020;
      s_wr = n_wr; s_st = n_st;
      pulse_poll();
`ifdef I2C_SEQ_TIMEOUT_EN
      k = 0;
      while (n_wr < s_wr + 2 && k < 9000) begin @(negedge clk_50); k++; end
      check("to_retry_writes", n_wr - s_wr, 2);
      check("to_retry_gap", st_time[s_st + 1] - st_time[s_st], 8195);
      check("to_err", err_count, 1);
      check("to_busy", busy, 1);
`else
      tick(9000);
      check("hang_busy", busy, 1);
      check("hang_writes", n_wr - s_wr, 1);
      check("hang_err", err_count, 0);
`endif
      rst_n = 1'b0;
      hang = 1'b0;
      st_ptr = 9'h1FF;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("hang_rst_busy", busy, 0);

      check("protocol_errors", perr, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
